// File: rtl/pu_spi_bridge.sv
// pu_spi_bridge: SPI-slave (mode 0) bridge that lets an external host drive a
// processing unit. Each 40-bit frame carries cmd[7:0] + payload[31:0] on MOSI
// and returns status[7:0] + rd_data[31:0] on MISO.
//
// Ports:
//   clk, RST            system clock, synchronous active-high reset
//   spi_sclk/cs/mosi    asynchronous SPI pins (cs active-low), synchronised here
//   spi_miso            serial out, 0 while CS is high
//   signal_wr/sel/oe    single-cycle PU strobes, registered, high only in EXEC
//   data_to_pu          last written payload; attr_to_pu is tied to 0
//   data_from_pu/attr_from_pu  PU result, captured on a READ (cmd 0x03)
//
// Only DATA_WIDTH = 32 and ATTR_WIDTH <= 4 are meaningful: the frame payload
// and the status byte layout are fixed.
module pu_spi_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int INVALID    = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  spi_sclk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  signal_wr,
  output logic                  signal_sel,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_to_pu,
  output logic [ATTR_WIDTH-1:0] attr_to_pu,
  input  logic [DATA_WIDTH-1:0] data_from_pu,
  input  logic [ATTR_WIDTH-1:0] attr_from_pu
);

  localparam int FRAME_W = 40;

  localparam logic [7:0] CMD_NOP  = 8'h00;
  localparam logic [7:0] CMD_WRA  = 8'h01;
  localparam logic [7:0] CMD_WRB  = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Synchronisers: stages [0] and [1] form the 2-FF synchroniser, stage [2]
  // is the delayed copy used only for edge detection.
  logic [2:0] sclk_s;
  logic [2:0] cs_s;
  logic [1:0] mosi_s;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

  logic [FRAME_W-1:0]    rx_sr;
  logic [FRAME_W-1:0]    tx_sr;
  logic [5:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ATTR_WIDTH-1:0] attr_cap;
  logic                  err_cmd;
  logic                  err_frame;

  logic [3:0] attr_ext;
  logic [7:0] status;
  logic [7:0] cmd;

  // FSM decisions, consumed by the datapath register block
  logic frame_start;
  logic frame_bad;
  logic rx_shift;
  logic tx_shift;
  logic exec_go;
  logic wr_nxt, sel_nxt, oe_nxt;
  logic cmd_bad;

  always_ff @(posedge clk) begin
    if (RST) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk};
      cs_s   <= {cs_s[1:0], spi_cs};
      mosi_s <= {mosi_s[0], spi_mosi};
    end
  end

  assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
  assign cs_rise   =  cs_s[1]   & ~cs_s[2];
  assign cs_fall   = ~cs_s[1]   &  cs_s[2];
  assign mosi_bit  =  mosi_s[1];

  // Zero-extend the captured attribute into the 4-bit status field.
  always_comb begin
    attr_ext = 4'd0;
    attr_ext[ATTR_WIDTH-1:0] = attr_cap;
  end

  assign status = {attr_ext, 1'b0, attr_cap[INVALID], err_cmd, err_frame};
  assign cmd    = rx_sr[FRAME_W-1 -: 8];

  // Command decode only matters on the SHIFT->EXEC transition (strobes) and
  // in EXEC itself (error flag, read capture); rx_sr is frozen across both.
  assign cmd_bad = (cmd != CMD_NOP) && (cmd != CMD_WRA) &&
                   (cmd != CMD_WRB) && (cmd != CMD_READ);
  assign wr_nxt  = exec_go && ((cmd == CMD_WRA) || (cmd == CMD_WRB));
  assign sel_nxt = exec_go && (cmd == CMD_WRB);
  assign oe_nxt  = exec_go && (cmd == CMD_READ);

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_bad   = 1'b0;
    rx_shift    = 1'b0;
    tx_shift    = 1'b0;
    exec_go     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // A CS rise in the same cycle as an SCLK edge ends the frame and the
        // SCLK edge is dropped.
        if (cs_rise) begin
          if (bit_cnt == 6'd40) begin
            exec_go   = 1'b1;
            state_nxt = EXEC;
          end else begin
            frame_bad = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          rx_shift = sclk_rise;
          tx_shift = sclk_fall;
        end
      end
      EXEC: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rx_sr      <= '0;
      tx_sr      <= '0;
      bit_cnt    <= 6'd0;
      rd_data    <= '0;
      attr_cap   <= '0;
      err_cmd    <= 1'b0;
      err_frame  <= 1'b0;
      signal_wr  <= 1'b0;
      signal_sel <= 1'b0;
      signal_oe  <= 1'b0;
      data_to_pu <= '0;
    end else begin
      signal_wr  <= wr_nxt;
      signal_sel <= sel_nxt;
      signal_oe  <= oe_nxt;

      // Status is snapshotted at frame start, so each error is reported once
      // and a READ result only appears in the frame after the READ.
      if (frame_start) begin
        tx_sr     <= {status, rd_data};
        bit_cnt   <= 6'd0;
        err_cmd   <= 1'b0;
        err_frame <= 1'b0;
      end

      if (rx_shift) begin
        rx_sr <= {rx_sr[FRAME_W-2:0], mosi_bit};
        if (bit_cnt != 6'd63) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end

      if (tx_shift) begin
        tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end

      if (frame_bad) begin
        err_frame <= 1'b1;
      end

      if (wr_nxt) begin
        data_to_pu <= rx_sr[DATA_WIDTH-1:0];
      end

      // signal_oe is high during this EXEC cycle, so the PU output is valid now.
      if (state == EXEC) begin
        if (signal_oe) begin
          rd_data  <= data_from_pu;
          attr_cap <= attr_from_pu;
        end
        if (cmd_bad) begin
          err_cmd <= 1'b1;
        end
      end
    end
  end

  assign spi_miso   = ~cs_s[1] & tx_sr[FRAME_W-1];
  assign attr_to_pu = '0;

endmodule
